// File: rtl/console_pkg.sv
// Shared constants and types for the text_console character front end.
package console_pkg;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam logic [1:0] VU_REG_CURSOR_EN  = 2'b00;
    localparam logic [1:0] VU_REG_CURSOR_POS = 2'b01;
    localparam logic [1:0] VU_REG_CUR_START  = 2'b10;
    localparam logic [1:0] VU_REG_CUR_END    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_CLEAR_ROW,
        ST_CLEAR,
        ST_CURSOR
    } state_t;

endpackage

// File: rtl/console_cursor.sv
// Cursor row/column tracker; yields the linear text RAM index and wrap flags.
module console_cursor
    import console_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int ROWS  = DEF_ROWS,
    parameter int IDX_W = $clog2(ROWS * COLS)
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             i_advance,
    input  logic             i_newline,
    input  logic             i_cr,
    input  logic             i_bs,
    input  logic             i_home,
    output logic [IDX_W-1:0] o_index,
    output logic             o_scroll_needed,
    output logic             o_at_eol
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_last_row;
    logic             w_last_col;

    assign w_last_row      = (r_row == ROW_W'(ROWS - 1));
    assign w_last_col      = (r_col == COL_W'(COLS - 1));
    assign o_scroll_needed = w_last_row;
    assign o_at_eol        = w_last_col;
    assign o_index         = IDX_W'(r_row) * IDX_W'(COLS) + IDX_W'(r_col);

    // Row saturates at the last row; the scroll moves the text, not the cursor.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_home) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_newline || (i_advance && w_last_col)) begin
            r_col <= '0;
            if (!w_last_row) r_row <= r_row + 1'b1;
        end else if (i_advance) begin
            r_col <= r_col + 1'b1;
        end else if (i_cr) begin
            r_col <= '0;
        end else if (i_bs && (r_col != '0)) begin
            r_col <= r_col - 1'b1;
        end
    end

endmodule

// File: rtl/text_console.sv
// Byte-stream console: writes {attr,char} into the video unit text RAM,
// handles LF/CR/BS/FF, hardware scroll, and keeps the cursor register current.
//   state     | meaning
//   IDLE      | ready for a byte
//   WRITE     | store one printable character
//   SCROLL_RD | read entry i+COLS
//   SCROLL_WR | copy read data to entry i
//   CLEAR_ROW | blank the last row after a scroll
//   CLEAR     | blank the whole screen
//   CURSOR    | update the video unit cursor position
module text_console
    import console_pkg::*;
#(
    parameter int         COLS           = DEF_COLS,
    parameter int         ROWS           = DEF_ROWS,
    parameter logic [7:0] DEFAULT_ATTR   = 8'h07,
    parameter bit         CLEAR_ON_RESET = 1'b1,
    localparam int        TRAM_WIDTH     = $clog2(ROWS * COLS)
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                char_valid,
    input  logic [7:0]          char_data,
    output logic                char_ready,
    input  logic                attr_wenable,
    input  logic [7:0]          attr_wdata,
    output logic                busy,
    output logic [TRAM_WIDTH:0] tram_addr,
    output logic [15:0]         tram_wdata,
    output logic [1:0]          tram_wenable,
    input  logic [15:0]         tram_rdata,
    output logic [1:0]          reg_sel,
    output logic [15:0]         reg_wdata,
    output logic                reg_wenable
);
    localparam logic [TRAM_WIDTH-1:0] LAST_IDX   = TRAM_WIDTH'(ROWS * COLS - 1);
    localparam logic [TRAM_WIDTH-1:0] LAST_SRC   = TRAM_WIDTH'((ROWS - 1) * COLS - 1);
    localparam logic [TRAM_WIDTH-1:0] ROW_STRIDE = TRAM_WIDTH'(COLS);

    state_t                r_state, w_state_nxt;
    logic                  r_run;
    logic [TRAM_WIDTH-1:0] r_idx, w_idx_nxt;
    logic [7:0]            r_attr, r_op_attr, w_op_attr_nxt, r_char, w_char_nxt, w_attr_eff;
    logic                  w_advance, w_newline, w_cr, w_bs, w_home;
    logic                  w_scroll_needed, w_at_eol;
    logic [TRAM_WIDTH-1:0] w_cur_idx, w_rd_idx;

    console_cursor #(.COLS(COLS), .ROWS(ROWS), .IDX_W(TRAM_WIDTH)) u_cursor (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .i_advance       (w_advance),
        .i_newline       (w_newline),
        .i_cr            (w_cr),
        .i_bs            (w_bs),
        .i_home          (w_home),
        .o_index         (w_cur_idx),
        .o_scroll_needed (w_scroll_needed),
        .o_at_eol        (w_at_eol)
    );

    assign w_attr_eff = attr_wenable ? attr_wdata : r_attr;
    assign w_rd_idx   = r_idx + ROW_STRIDE;
    assign busy       = (r_state != ST_IDLE);

    // r_run holds every strobe low during reset and for the first cycle after it.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_op_attr_nxt = r_op_attr;
        w_char_nxt    = r_char;
        w_advance     = 1'b0;
        w_newline     = 1'b0;
        w_cr          = 1'b0;
        w_bs          = 1'b0;
        w_home        = 1'b0;
        char_ready    = 1'b0;
        tram_addr     = '0;
        tram_wdata    = '0;
        tram_wenable  = 2'b00;
        reg_sel       = 2'b00;
        reg_wdata     = '0;
        reg_wenable   = 1'b0;
        if (r_run) begin
            unique case (r_state)
                ST_IDLE: begin
                    char_ready = 1'b1;
                    if (char_valid) begin
                        if (char_data >= CH_SPACE) begin
                            w_char_nxt  = char_data;
                            w_state_nxt = ST_WRITE;
                        end else if (char_data == CH_LF) begin
                            w_newline = 1'b1;
                            if (w_scroll_needed) begin
                                w_idx_nxt     = '0;
                                w_op_attr_nxt = w_attr_eff;
                                w_state_nxt   = ST_SCROLL_RD;
                            end else begin
                                w_state_nxt = ST_CURSOR;
                            end
                        end else if (char_data == CH_CR) begin
                            w_cr        = 1'b1;
                            w_state_nxt = ST_CURSOR;
                        end else if (char_data == CH_BS) begin
                            w_bs        = 1'b1;
                            w_state_nxt = ST_CURSOR;
                        end else if (char_data == CH_FF) begin
                            w_home        = 1'b1;
                            w_idx_nxt     = '0;
                            w_op_attr_nxt = w_attr_eff;
                            w_state_nxt   = ST_CLEAR;
                        end
                    end
                end
                ST_WRITE: begin
                    tram_addr    = {w_cur_idx, 1'b0};
                    tram_wdata   = {r_attr, r_char};
                    tram_wenable = 2'b11;
                    w_advance    = 1'b1;
                    if (w_scroll_needed && w_at_eol) begin
                        w_idx_nxt     = '0;
                        w_op_attr_nxt = w_attr_eff;
                        w_state_nxt   = ST_SCROLL_RD;
                    end else begin
                        w_state_nxt = ST_CURSOR;
                    end
                end
                ST_SCROLL_RD: begin
                    tram_addr   = {w_rd_idx, 1'b0};
                    w_state_nxt = ST_SCROLL_WR;
                end
                ST_SCROLL_WR: begin
                    tram_addr    = {r_idx, 1'b0};
                    tram_wdata   = tram_rdata;
                    tram_wenable = 2'b11;
                    w_idx_nxt    = r_idx + 1'b1;
                    // The index after the last copy is the first entry of the last row.
                    w_state_nxt  = (r_idx == LAST_SRC) ? ST_CLEAR_ROW : ST_SCROLL_RD;
                end
                ST_CLEAR_ROW, ST_CLEAR: begin
                    tram_addr    = {r_idx, 1'b0};
                    tram_wdata   = {r_op_attr, CH_SPACE};
                    tram_wenable = 2'b11;
                    w_idx_nxt    = r_idx + 1'b1;
                    if (r_idx == LAST_IDX) w_state_nxt = ST_CURSOR;
                end
                ST_CURSOR: begin
                    reg_sel     = VU_REG_CURSOR_POS;
                    reg_wdata   = 16'(w_cur_idx);
                    reg_wenable = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_CURSOR;
            r_run     <= 1'b0;
            r_idx     <= '0;
            r_attr    <= DEFAULT_ATTR;
            r_op_attr <= DEFAULT_ATTR;
            r_char    <= '0;
        end else begin
            r_run     <= 1'b1;
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_op_attr <= w_op_attr_nxt;
            r_char    <= w_char_nxt;
            if (attr_wenable) r_attr <= attr_wdata;
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Randomized bench for text_console with a screen-level reference model.
module tb_text_console;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        attr_wenable = 1'b0;
    logic [7:0]  attr_wdata = 8'h00;
    logic        busy;
    logic [12:0] tram_addr;
    logic [15:0] tram_wdata;
    logic [1:0]  tram_wenable;
    logic [15:0] tram_rdata;
    logic [1:0]  reg_sel;
    logic [15:0] reg_wdata;
    logic        reg_wenable;

    text_console dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .char_valid   (char_valid),
        .char_data    (char_data),
        .char_ready   (char_ready),
        .attr_wenable (attr_wenable),
        .attr_wdata   (attr_wdata),
        .busy         (busy),
        .tram_addr    (tram_addr),
        .tram_wdata   (tram_wdata),
        .tram_wenable (tram_wenable),
        .tram_rdata   (tram_rdata),
        .reg_sel      (reg_sel),
        .reg_wdata    (reg_wdata),
        .reg_wenable  (reg_wenable)
    );

    always #5 sys_clk = ~sys_clk;

    // Text RAM model with one-cycle read latency; pl_* lets the bench preload it.
    logic [15:0] tram_mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_idx = 12'd0;
    logic [15:0] pl_data = 16'd0;
    always @(posedge sys_clk) begin
        if (pl_en) tram_mem[pl_idx] <= pl_data;
        else if (tram_wenable == 2'b11) tram_mem[tram_addr[12:1]] <= tram_wdata;
        tram_rdata <= tram_mem[tram_addr[12:1]];
    end

    int n_vec = 0;
    int n_err = 0;

    int          m_row, m_col;
    logic [7:0]  m_attr;
    logic [15:0] m_scr [0:2399];

    logic [12:0] cap_addr [$];
    logic [15:0] cap_data [$];
    int          cap_wcyc [$];
    logic [15:0] cap_reg  [$];
    logic [1:0]  cap_sel  [$];
    int          cap_rcyc [$];
    int          cap_lat, cap_busy;

    task automatic model_reset();
        m_row = 0; m_col = 0; m_attr = 8'h07;
        for (int i = 0; i < 2400; i++) m_scr[i] = {m_attr, 8'h20};
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20) begin
            m_scr[m_row * 80 + m_col] = {m_attr, b};
            m_col++;
            if (m_col == 80) begin m_col = 0; m_row++; end
        end else if (b == 8'h0A) begin
            m_col = 0; m_row++;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            m_row = 0; m_col = 0;
            for (int i = 0; i < 2400; i++) m_scr[i] = {m_attr, 8'h20};
        end
        if (m_row == 30) begin
            for (int i = 0; i < 2320; i++) m_scr[i] = m_scr[i + 80];
            for (int i = 2320; i < 2400; i++) m_scr[i] = {m_attr, 8'h20};
            m_row = 29;
        end
    endtask

    function automatic bit is_silent(input logic [7:0] b);
        return (b < 8'h20) && (b != 8'h0A) && (b != 8'h0D) && (b != 8'h08) && (b != 8'h0C);
    endfunction

    // Records every strobe until char_ready; an expired bound is itself a miscompare.
    task automatic capture(input int max_cyc);
        cap_addr.delete(); cap_data.delete(); cap_wcyc.delete();
        cap_reg.delete(); cap_sel.delete(); cap_rcyc.delete();
        cap_lat = 0; cap_busy = 0;
        forever begin
            @(negedge sys_clk);
            cap_lat++;
            if (tram_wenable == 2'b11) begin
                cap_addr.push_back(tram_addr); cap_data.push_back(tram_wdata); cap_wcyc.push_back(cap_lat);
            end
            if (reg_wenable) begin
                cap_reg.push_back(reg_wdata); cap_sel.push_back(reg_sel); cap_rcyc.push_back(cap_lat);
            end
            if (busy) cap_busy++;
            if (char_ready) break;
            if (cap_lat >= max_cyc) begin
                n_vec++; n_err++;
                $display("FAIL timeout: char_ready still %b after %0d cycles, required 1", char_ready, cap_lat);
                break;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        @(negedge sys_clk);
        while (!char_ready && w < 10000) begin @(negedge sys_clk); w++; end
        char_valid = 1'b1; char_data = b;
        @(posedge sys_clk); #1;
        char_valid = 1'b0; char_data = 8'($urandom);
        capture(6000);
    endtask

    task automatic set_attr(input logic [7:0] a);
        @(negedge sys_clk); attr_wenable = 1'b1; attr_wdata = a;
        @(posedge sys_clk); #1; attr_wenable = 1'b0;
        m_attr = a;
    endtask

    task automatic preload(input int idx, input logic [15:0] d);
        @(negedge sys_clk); pl_en = 1'b1; pl_idx = 12'(idx); pl_data = d;
        @(posedge sys_clk); #1; pl_en = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2400; i++) preload(i, 16'($urandom));
        @(negedge sys_clk);
        n_vec++;
        if (tram_wenable !== 2'b00 || reg_wenable !== 1'b0 || char_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: wen=%b regwen=%b ready=%b busy=%b, required 00 0 0 1",
                     tram_wenable, reg_wenable, char_ready, busy);
        end
        rst_n = 1'b1;
        capture(6000);
        model_reset();
        n_vec++;
        if (cap_addr.size() != 2400) begin
            n_err++; $display("FAIL reset_clear_count: %0d writes, required 2400", cap_addr.size());
        end
        foreach (cap_addr[i]) if (cap_addr[i] !== 13'(2 * i) || cap_data[i] !== 16'h0720) bad++;
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL reset_clear_seq: %0d bad writes, required 0", bad); end
        n_vec++;
        if (cap_reg.size() != 1 || cap_reg[0] !== 16'd0 || cap_sel[0] !== 2'b01) begin
            n_err++; $display("FAIL reset_cursor: %0d reg writes, first %h, required 1 write of 0000 sel 01",
                              cap_reg.size(), (cap_reg.size() > 0) ? cap_reg[0] : 16'hxxxx);
        end
    endtask

    task automatic test_attr_char();
        set_attr(8'h1F);
        send_byte(8'h41);
        model_byte(8'h41);
        n_vec++;
        if (cap_addr.size() != 1 || cap_addr[0] !== 13'd0 || cap_data[0] !== 16'h1F41 || cap_wcyc[0] != 1) begin
            n_err++; $display("FAIL char_write: %0d writes, addr %h data %h, required 1 write 0000 <- 1f41 at N+1",
                              cap_addr.size(), (cap_addr.size() > 0) ? cap_addr[0] : 13'hx,
                              (cap_data.size() > 0) ? cap_data[0] : 16'hx);
        end
        n_vec++;
        if (cap_reg.size() != 1 || cap_reg[0] !== 16'd1 || cap_rcyc[0] != 2) begin
            n_err++; $display("FAIL char_cursor: %0d reg writes, data %h, required 0001 at N+2",
                              cap_reg.size(), (cap_reg.size() > 0) ? cap_reg[0] : 16'hx);
        end
        n_vec++;
        if (cap_lat != 3) begin n_err++; $display("FAIL char_latency: ready after %0d cycles, required 3", cap_lat); end
    endtask

    task automatic test_line_fill();
        send_byte(8'h0D); model_byte(8'h0D);
        n_vec++;
        if (cap_addr.size() != 0 || cap_reg.size() != 1 || cap_reg[0] !== 16'd0) begin
            n_err++; $display("FAIL cr_home: %0d writes, %0d reg writes, required 0 and 1 of 0000",
                              cap_addr.size(), cap_reg.size());
        end
        for (int k = 0; k < 80; k++) begin send_byte(8'h78); model_byte(8'h78); end
        n_vec++;
        if (cap_addr.size() != 1 || cap_addr[0] !== 13'd158 || cap_data[0] !== 16'h1F78) begin
            n_err++; $display("FAIL line_last_write: addr %0d data %h, required 158 1f78",
                              (cap_addr.size() > 0) ? cap_addr[0] : 13'hx, (cap_data.size() > 0) ? cap_data[0] : 16'hx);
        end
        n_vec++;
        if (cap_reg.size() != 1 || cap_reg[0] !== 16'd80) begin
            n_err++; $display("FAIL line_wrap_cursor: %0d, required 80", (cap_reg.size() > 0) ? cap_reg[0] : 16'hx);
        end
    endtask

    task automatic test_ctrl();
        for (int k = 0; k < 5; k++) begin
            logic [7:0] b = 8'($urandom_range(32, 255));
            send_byte(b); model_byte(b);
        end
        send_byte(8'h0D); model_byte(8'h0D);
        n_vec++;
        if (cap_reg.size() != 1 || cap_reg[0] !== 16'd80) begin
            n_err++; $display("FAIL cr_col5: cursor %0d, required 80", (cap_reg.size() > 0) ? cap_reg[0] : 16'hx);
        end
        send_byte(8'h08); model_byte(8'h08);
        n_vec++;
        if (cap_addr.size() != 0 || cap_reg.size() != 1 || cap_reg[0] !== 16'd80) begin
            n_err++; $display("FAIL bs_col0: %0d writes, cursor %0d, required 0 and 80",
                              cap_addr.size(), (cap_reg.size() > 0) ? cap_reg[0] : 16'hx);
        end
        for (int k = 0; k < 3; k++) begin send_byte(8'h2E); model_byte(8'h2E); end
        send_byte(8'h08); model_byte(8'h08);
        n_vec++;
        if (cap_addr.size() != 0 || cap_reg.size() != 1 || cap_reg[0] !== 16'd82) begin
            n_err++; $display("FAIL bs_col3: %0d writes, cursor %0d, required 0 and 82",
                              cap_addr.size(), (cap_reg.size() > 0) ? cap_reg[0] : 16'hx);
        end
        send_byte(8'h07); model_byte(8'h07);
        n_vec++;
        if (cap_addr.size() != 0 || cap_reg.size() != 0 || cap_lat != 1) begin
            n_err++; $display("FAIL bel_drop: %0d writes, %0d reg writes, ready after %0d, required 0 0 1",
                              cap_addr.size(), cap_reg.size(), cap_lat);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 200; k++) begin
            logic [7:0] b;
            int r, pre_idx;
            logic [7:0] pre_attr;
            bit silent;
            if ($urandom_range(0, 9) == 0) set_attr(8'($urandom));
            r = $urandom_range(0, 99);
            if (r < 70) b = 8'($urandom_range(32, 255));
            else if (r < 78) b = 8'h0A;
            else if (r < 84) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else begin
                b = 8'($urandom_range(0, 31));
                while (!is_silent(b)) b = 8'($urandom_range(0, 31));
            end
            pre_idx = m_row * 80 + m_col; pre_attr = m_attr; silent = is_silent(b);
            send_byte(b);
            model_byte(b);
            n_vec++;
            if (cap_reg.size() != (silent ? 0 : 1)) begin
                n_err++; $display("FAIL rand_reg_count k=%0d byte %h: %0d, required %0d", k, b, cap_reg.size(), silent ? 0 : 1);
            end else if (!silent) begin
                n_vec++;
                if (cap_reg[0] !== 16'(m_row * 80 + m_col) || cap_sel[0] !== 2'b01) begin
                    n_err++; $display("FAIL rand_cursor k=%0d byte %h: %0d sel %b, required %0d sel 01",
                                      k, b, cap_reg[0], cap_sel[0], m_row * 80 + m_col);
                end
            end
            if (b >= 8'h20) begin
                n_vec++;
                if (cap_addr.size() == 0 || cap_addr[0] !== 13'(2 * pre_idx) || cap_data[0] !== {pre_attr, b}) begin
                    n_err++; $display("FAIL rand_write k=%0d: addr %0d data %h, required %0d %h", k,
                                      (cap_addr.size() > 0) ? cap_addr[0] : 13'hx,
                                      (cap_data.size() > 0) ? cap_data[0] : 16'hx, 2 * pre_idx, {pre_attr, b});
                end
            end else if (silent) begin
                n_vec++;
                if (cap_addr.size() != 0 || cap_lat != 1) begin
                    n_err++; $display("FAIL rand_drop k=%0d byte %h: %0d writes, ready after %0d, required 0 1",
                                      k, b, cap_addr.size(), cap_lat);
                end
            end
        end
        for (int i = 0; i < 2400; i++) if (tram_mem[i] !== m_scr[i]) bad++;
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL rand_screen: %0d entries differ, required 0", bad); end
    endtask

    task automatic test_scroll();
        int bad = 0;
        set_attr(8'h07);
        send_byte(8'h0C); model_byte(8'h0C);
        n_vec++;
        if (cap_addr.size() != 2400 || cap_reg.size() != 1 || cap_reg[0] !== 16'd0) begin
            n_err++; $display("FAIL ff_clear: %0d writes, %0d reg writes, required 2400 and 1 of 0",
                              cap_addr.size(), cap_reg.size());
        end
        preload(80, 16'h0742); m_scr[80] = 16'h0742;
        for (int k = 0; k < 29; k++) begin send_byte(8'h0A); model_byte(8'h0A); end
        n_vec++;
        if (cap_reg.size() != 1 || cap_reg[0] !== 16'd2320 || cap_addr.size() != 0) begin
            n_err++; $display("FAIL lf_to_row29: cursor %0d, %0d writes, required 2320 and 0",
                              (cap_reg.size() > 0) ? cap_reg[0] : 16'hx, cap_addr.size());
        end
        send_byte(8'h0A); model_byte(8'h0A);
        n_vec++;
        if (cap_busy != 4721) begin n_err++; $display("FAIL scroll_busy: %0d cycles, required 4721", cap_busy); end
        n_vec++;
        if (cap_reg.size() != 1 || cap_reg[0] !== 16'd2320) begin
            n_err++; $display("FAIL scroll_cursor: %0d, required 2320", (cap_reg.size() > 0) ? cap_reg[0] : 16'hx);
        end
        n_vec++;
        if (tram_mem[0] !== 16'h0742) begin
            n_err++; $display("FAIL scroll_entry0: %h, required 0742", tram_mem[0]);
        end
        for (int i = 2320; i < 2400; i++) if (tram_mem[i] !== 16'h0720) bad++;
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL scroll_last_row: %0d entries not 0720, required 0", bad); end
        bad = 0;
        for (int i = 0; i < 2400; i++) if (tram_mem[i] !== m_scr[i]) bad++;
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL scroll_screen: %0d entries differ, required 0", bad); end
    endtask

    task automatic test_reset_mid_scroll();
        int bad = 0;
        set_attr(8'h5A);
        @(negedge sys_clk);
        char_valid = 1'b1; char_data = 8'h0A;
        @(posedge sys_clk); #1; char_valid = 1'b0;
        repeat ($urandom_range(100, 200)) @(negedge sys_clk);
        #2; rst_n = 1'b0; #1;
        n_vec++;
        if (tram_wenable !== 2'b00 || reg_wenable !== 1'b0 || char_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL midreset_outputs: wen=%b regwen=%b ready=%b busy=%b, required 00 0 0 1",
                              tram_wenable, reg_wenable, char_ready, busy);
        end
        @(negedge sys_clk); rst_n = 1'b1;
        capture(6000);
        model_reset();
        n_vec++;
        if (cap_addr.size() != 2400 || cap_addr[0] !== 13'd0) begin
            n_err++; $display("FAIL midreset_restart: %0d writes, first addr %0d, required 2400 from 0",
                              cap_addr.size(), (cap_addr.size() > 0) ? cap_addr[0] : 13'hx);
        end
        foreach (cap_addr[i]) if (cap_addr[i] !== 13'(2 * i) || cap_data[i] !== 16'h0720) bad++;
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL midreset_seq: %0d bad writes, required 0", bad); end
        n_vec++;
        if (cap_reg.size() != 1 || cap_reg[0] !== 16'd0) begin
            n_err++; $display("FAIL midreset_cursor: %0d reg writes, required 1 of 0", cap_reg.size());
        end
    endtask

    initial begin
        test_reset();
        test_attr_char();
        test_line_fill();
        test_ctrl();
        test_random();
        test_scroll();
        test_reset_mid_scroll();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
